core_alu_mc: RTL

CORE_ALU_MC -- requirements
Module: core_alu_mc

---
 rtl/core_alu_mc.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/core_alu_mc.sv
// core_alu_mc: multi-cycle ALU with a valid/ready handshake on both sides.
// Single-cycle operations finish one cycle after they are accepted.
// Result, zero flag and out_valid are held in DONE until the consumer takes them.
// Optional feature macro: CORE_ALU_MUL_EN. When it is defined, the block adds
// MUL (code 10) and MULHU (code 11) as an XLEN-cycle radix-2 shift-add multiplier.
// When it is not defined, codes 10 and 11 act like any other undefined code.
module core_alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] oprend_1,
    input  logic [XLEN-1:0] oprend_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero
);

    // Operation codes
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
`ifdef CORE_ALU_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DONE = 2'b10
    } state_t;
`endif

    // Returns 1 when the whole result word is zero.
    function automatic logic is_zero(input logic [XLEN-1:0] v);
        return (v == {XLEN{1'b0}});
    endfunction

    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;

    logic [XLEN-1:0]   alu_res_s;
    logic [SHW-1:0]    shamt_s;

`ifdef CORE_ALU_MUL_EN
    logic [SHW-1:0]    mul_cnt_q;
    logic [2*XLEN-1:0] mul_acc_q;     // {partial high half, remaining multiplier bits}
    logic [XLEN-1:0]   mul_mcand_q;
    logic              mul_hi_q;      // 1 = MULHU, 0 = MUL

    logic              is_mul_s;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_step_s;
    logic [XLEN-1:0]   mul_res_s;
`endif

    assign shamt_s = oprend_2[SHW-1:0];

    // Single-cycle datapath: result of the operation currently on the inputs
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (ctrl)
            OP_ADD:  alu_res_s = oprend_1 + oprend_2;
            OP_SUB:  alu_res_s = oprend_1 - oprend_2;
            OP_AND:  alu_res_s = oprend_1 & oprend_2;
            OP_OR:   alu_res_s = oprend_1 | oprend_2;
            OP_XOR:  alu_res_s = oprend_1 ^ oprend_2;
            OP_SLL:  alu_res_s = oprend_1 << shamt_s;
            OP_SRL:  alu_res_s = oprend_1 >> shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(oprend_1) >>> shamt_s);
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(oprend_1) < $signed(oprend_2))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (oprend_1 < oprend_2)};
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

`ifdef CORE_ALU_MUL_EN
    // Multiplier step: add the multiplicand when the current multiplier bit is set, then shift right
    always_comb begin
        is_mul_s = (ctrl == OP_MUL) || (ctrl == OP_MULHU);
        if (mul_acc_q[0]) begin
            mul_sum_s = {1'b0, mul_acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_mcand_q};
        end else begin
            mul_sum_s = {1'b0, mul_acc_q[2*XLEN-1:XLEN]};
        end
        mul_step_s = {mul_sum_s, mul_acc_q[XLEN-1:1]};
        if (mul_hi_q) begin
            mul_res_s = mul_step_s[2*XLEN-1:XLEN];
        end else begin
            mul_res_s = mul_step_s[XLEN-1:0];
        end
    end
`endif

    // Control FSM with registered handshake, result and zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= {XLEN{1'b0}};
            zero_q      <= 1'b1;
`ifdef CORE_ALU_MUL_EN
            mul_cnt_q   <= {SHW{1'b0}};
            mul_acc_q   <= {(2*XLEN){1'b0}};
            mul_mcand_q <= {XLEN{1'b0}};
            mul_hi_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
`ifdef CORE_ALU_MUL_EN
                        if (is_mul_s) begin
                            state_q     <= ST_BUSY;
                            in_ready_q  <= 1'b0;
                            mul_cnt_q   <= {SHW{1'b0}};
                            mul_acc_q   <= {{XLEN{1'b0}}, oprend_2};
                            mul_mcand_q <= oprend_1;
                            mul_hi_q    <= (ctrl == OP_MULHU);
                        end else
`endif
                        begin
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res_s;
                            zero_q      <= is_zero(alu_res_s);
                        end
                    end
                end
`ifdef CORE_ALU_MUL_EN
                ST_BUSY: begin
                    // One multiplier bit per cycle; the XLEN-th step writes the result.
                    mul_acc_q <= mul_step_s;
                    mul_cnt_q <= mul_cnt_q + SHW'(1);
                    if (mul_cnt_q == SHW'(XLEN - 1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_res_s;
                        zero_q      <= is_zero(mul_res_s);
                    end
                end
`endif
                ST_DONE: begin
                    // Hold the result until it is consumed. in_ready rises one cycle later.
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign alu_result = result_q;
    assign zero       = zero_q;

endmodule
